// File: rtl/spi_slave_burst.sv
// SPI mode-0 burst slave in the SPI bit-clock domain: header {rd_addr, wr_addr}, then up to
// MAX_BURST data words, each producing one register write plus a prefetch of the next read word.
module spi_slave_burst #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RD_ADDR_WIDTH = 4,
    parameter int unsigned WR_ADDR_WIDTH = 4,
    parameter int unsigned MAX_BURST     = 4,
    parameter int unsigned ADDR_INC      = 1
) (
    input  logic                           spi_clk_iob,
    input  logic                           reset_n,
    input  logic                           spi_cs_n,
    input  logic                           spi_mosi,
    output logic                           spi_miso,
    output logic                           spi_miso_disable,
    output logic                           rd_en,
    output logic [RD_ADDR_WIDTH-1:0]       rd_addr,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           wr_en,
    output logic [WR_ADDR_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           frame_done,
    output logic [$clog2(MAX_BURST+1)-1:0] frame_words,
    output logic                           frame_abort
);
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned RAW = RD_ADDR_WIDTH;
    localparam int unsigned WAW = WR_ADDR_WIDTH;
    localparam int unsigned HW  = RAW + WAW;
    localparam int unsigned HSW = (RAW > WAW) ? RAW : WAW;
    localparam int unsigned BCW = $clog2((HW > DW) ? HW : DW);
    localparam int unsigned WCW = $clog2(MAX_BURST + 1);
    localparam bit          INC = (ADDR_INC != 0);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_d;
    logic [WCW-1:0]   word_cnt, word_cnt_d;
    logic [HSW-2:0]   hdr_sr, hdr_sr_d;
    logic [DW-2:0]    din_sr, din_sr_d;
    logic [DW-1:0]    miso_sr, miso_sr_d;
    logic [RAW-1:0]   rd_base, rd_base_d;
    logic [WAW-1:0]   wr_base, wr_base_d;

    logic             rd_en_d, wr_en_d, frame_done_d, frame_abort_d;
    logic [RAW-1:0]   rd_addr_d;
    logic [WAW-1:0]   wr_addr_d;
    logic [DW-1:0]    wr_data_d;
    logic [WCW-1:0]   frame_words_d;

    logic             cs_low;
    logic [HSW-2:0]   hdr_base;
    logic [HSW-1:0]   hdr_next;
    logic [DW-1:0]    din_next;
    logic [BCW-1:0]   hdr_idx;
    logic             rd_field_done, hdr_done, word_first, word_last, last_word;
    logic [RAW-1:0]   rd_off;
    logic [WAW-1:0]   wr_off;

    // Field decode; the IDLE edge that opens a frame captures header bit 0.
    assign cs_low        = !spi_cs_n;
    assign hdr_base      = (state == ST_HDR) ? hdr_sr : '0;
    assign hdr_next      = {hdr_base, spi_mosi};
    assign din_next      = {din_sr, spi_mosi};
    assign hdr_idx       = (state == ST_HDR) ? bit_cnt : '0;
    assign rd_field_done = cs_low && ((state == ST_IDLE) || (state == ST_HDR))
                           && (hdr_idx == BCW'(RAW - 1));
    assign hdr_done      = cs_low && (state == ST_HDR) && (bit_cnt == BCW'(HW - 1));
    assign word_first    = cs_low && (state == ST_DATA) && (bit_cnt == '0);
    assign word_last     = cs_low && (state == ST_DATA) && (bit_cnt == BCW'(DW - 1));
    assign last_word     = (word_cnt == WCW'(MAX_BURST - 1));
    assign rd_off        = INC ? RAW'(word_cnt + WCW'(1)) : '0;
    assign wr_off        = INC ? WAW'(word_cnt) : '0;

    // State register
    always_ff @(posedge spi_clk_iob) begin
        if (!reset_n) state <= ST_SYNC;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC: if (!cs_low) state_nxt = ST_IDLE;
            ST_IDLE: if (cs_low)  state_nxt = ST_HDR;
            ST_HDR: begin
                if (!cs_low)       state_nxt = ST_IDLE;
                else if (hdr_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (!cs_low)                    state_nxt = ST_IDLE;
                else if (word_last && last_word) state_nxt = ST_DONE;
            end
            ST_DONE: if (!cs_low) state_nxt = ST_IDLE;
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr;
        rd_base_d     = rd_base;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr;
        wr_data_d     = wr_data;
        wr_base_d     = wr_base;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        frame_words_d = frame_words;
        bit_cnt_d     = bit_cnt;
        word_cnt_d    = word_cnt;
        hdr_sr_d      = hdr_sr;
        din_sr_d      = din_sr;
        miso_sr_d     = miso_sr;
        case (state)
            ST_SYNC: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
            end
            ST_IDLE: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                if (cs_low) begin
                    hdr_sr_d  = hdr_next[HSW-2:0];
                    bit_cnt_d = BCW'(1);
                end
            end
            ST_HDR: begin
                if (!cs_low) begin
                    frame_done_d  = 1'b1;
                    frame_abort_d = 1'b1;
                    frame_words_d = '0;
                end else begin
                    hdr_sr_d = hdr_next[HSW-2:0];
                    if (hdr_done) begin
                        bit_cnt_d = '0;
                        wr_base_d = hdr_next[WAW-1:0];
                        miso_sr_d = rd_data;
                    end else begin
                        bit_cnt_d = bit_cnt + BCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (!cs_low) begin
                    frame_done_d  = 1'b1;
                    frame_abort_d = (bit_cnt != '0);
                    frame_words_d = word_cnt;
                end else begin
                    din_sr_d = din_next[DW-2:0];
                    if (word_last) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = wr_base + wr_off;
                        wr_data_d  = din_next;
                        word_cnt_d = word_cnt + WCW'(1);
                        bit_cnt_d  = '0;
                        miso_sr_d  = rd_data;
                    end else begin
                        bit_cnt_d = bit_cnt + BCW'(1);
                        miso_sr_d = {miso_sr[DW-2:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                if (!cs_low) begin
                    frame_done_d  = 1'b1;
                    frame_words_d = word_cnt;
                end
            end
            default: ;
        endcase
        if (rd_field_done) begin
            rd_en_d   = 1'b1;
            rd_addr_d = hdr_next[RAW-1:0];
            rd_base_d = hdr_next[RAW-1:0];
        end
        if (word_first && !last_word) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_base + rd_off;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge spi_clk_iob) begin
        if (!reset_n) begin
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_base     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_base     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_words <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            hdr_sr      <= '0;
            din_sr      <= '0;
            miso_sr     <= '0;
        end else begin
            rd_en       <= rd_en_d;
            rd_addr     <= rd_addr_d;
            rd_base     <= rd_base_d;
            wr_en       <= wr_en_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            wr_base     <= wr_base_d;
            frame_done  <= frame_done_d;
            frame_abort <= frame_abort_d;
            frame_words <= frame_words_d;
            bit_cnt     <= bit_cnt_d;
            word_cnt    <= word_cnt_d;
            hdr_sr      <= hdr_sr_d;
            din_sr      <= din_sr_d;
            miso_sr     <= miso_sr_d;
        end
    end

    // MISO pad flops launch on the falling edge so the master samples a settled bit.
    always_ff @(negedge spi_clk_iob) begin
        if (!reset_n) begin
            spi_miso         <= 1'b0;
            spi_miso_disable <= 1'b1;
        end else begin
            spi_miso         <= (state == ST_DATA) ? miso_sr[DW-1] : 1'b0;
            spi_miso_disable <= (state == ST_SYNC) || (state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Self-checking bench for spi_slave_burst: one ADDR_INC=1 and one ADDR_INC=0 instance share stimulus
// and are compared each cycle against a frame-position model of the protocol.
module tb_spi_slave_burst;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 4;
    localparam int unsigned WW = 4;
    localparam int unsigned MB = 4;
    localparam int unsigned HW = RW + WW;
    localparam int unsigned FW = 3;

    logic spi_clk_iob = 1'b0;
    always #5 spi_clk_iob = ~spi_clk_iob;

    logic          reset_n, spi_cs_n, spi_mosi;
    logic [1:0]    rd_en_v, wr_en_v, done_v, abort_v, miso_v, dis_v;
    logic [RW-1:0] rd_addr_v [2];
    logic [WW-1:0] wr_addr_v [2];
    logic [DW-1:0] wr_data_v [2];
    logic [DW-1:0] rd_data_v [2];
    logic [FW-1:0] words_v   [2];

    spi_slave_burst #(.DATA_WIDTH(DW), .RD_ADDR_WIDTH(RW), .WR_ADDR_WIDTH(WW),
                      .MAX_BURST(MB), .ADDR_INC(1)) u_inc (
        .spi_clk_iob(spi_clk_iob), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(miso_v[1]), .spi_miso_disable(dis_v[1]), .rd_en(rd_en_v[1]),
        .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]), .wr_en(wr_en_v[1]),
        .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .frame_done(done_v[1]),
        .frame_words(words_v[1]), .frame_abort(abort_v[1]));

    spi_slave_burst #(.DATA_WIDTH(DW), .RD_ADDR_WIDTH(RW), .WR_ADDR_WIDTH(WW),
                      .MAX_BURST(MB), .ADDR_INC(0)) u_fix (
        .spi_clk_iob(spi_clk_iob), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(miso_v[0]), .spi_miso_disable(dis_v[0]), .rd_en(rd_en_v[0]),
        .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]), .wr_en(wr_en_v[0]),
        .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .frame_done(done_v[0]),
        .frame_words(words_v[0]), .frame_abort(abort_v[0]));

    int checks, errors;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] tx  [8];

    // Model state: position of the next bit within the current frame.
    bit            armed, m_sync, m_frame;
    int            m_pos, m_rdb, m_wrb;
    logic [HW-1:0] m_hdr;
    logic [DW-1:0] m_word;

    bit            e_rd_en, e_wr_en, e_done, e_abort, e_dis, obs_valid;
    int            e_words, obs_w;
    logic [RW-1:0] e_rd_addr [2];
    logic [WW-1:0] e_wr_addr [2];
    logic [DW-1:0] e_wr_data;
    logic [1:0]    e_miso;
    logic [DW-1:0] rd_lat [2];

    int            wr_cnt [2], rd_cnt [2], done_cnt [2];
    logic          last_abort [2];
    logic [FW-1:0] last_words [2];
    logic [WW-1:0] wlog_a [2][8];
    logic [DW-1:0] wlog_d [2][8];
    logic [RW-1:0] rlog   [2][8];
    logic [DW-1:0] miso_obs [2][4];

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d] actual 0x%0h required 0x%0h", name, inst, act, req);
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; rd_cnt[i] = 0; done_cnt[i] = 0;
            for (int k = 0; k < 4; k++) miso_obs[i][k] = '0;
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            if (armed) begin
                chk("rd_en", i, 32'(rd_en_v[i]), 32'(e_rd_en));
                chk("wr_en", i, 32'(wr_en_v[i]), 32'(e_wr_en));
                chk("frame_done", i, 32'(done_v[i]), 32'(e_done));
                chk("frame_words", i, 32'(words_v[i]), 32'(e_words));
                chk("miso", i, 32'(miso_v[i]), 32'(e_miso[i]));
                chk("miso_disable", i, 32'(dis_v[i]), 32'(e_dis));
                if (e_rd_en) chk("rd_addr", i, 32'(rd_addr_v[i]), 32'(e_rd_addr[i]));
                if (e_wr_en) begin
                    chk("wr_addr", i, 32'(wr_addr_v[i]), 32'(e_wr_addr[i]));
                    chk("wr_data", i, 32'(wr_data_v[i]), 32'(e_wr_data));
                end
                if (e_done) chk("frame_abort", i, 32'(abort_v[i]), 32'(e_abort));
            end
            if (rd_en_v[i] === 1'b1) begin
                rd_lat[i] = mem[rd_addr_v[i]];
                if (rd_cnt[i] < 8) rlog[i][rd_cnt[i]] = rd_addr_v[i];
                rd_cnt[i]++;
            end
            if (wr_en_v[i] === 1'b1) begin
                if (wr_cnt[i] < 8) begin
                    wlog_a[i][wr_cnt[i]] = wr_addr_v[i];
                    wlog_d[i][wr_cnt[i]] = wr_data_v[i];
                end
                wr_cnt[i]++;
            end
            if (done_v[i] === 1'b1) begin
                done_cnt[i]++;
                last_abort[i] = abort_v[i];
                last_words[i] = words_v[i];
            end
            if (obs_valid) miso_obs[i][obs_w] = {miso_obs[i][obs_w][DW-2:0], miso_v[i]};
        end
    endtask

    // Expected outputs after the coming posedge, from the bit's position within the frame.
    task automatic model(input bit rst_v, input bit cs_v, input bit mosi_v);
        int p, w, b, dw;
        bit sample;
        logic [DW-1:0] t;
        armed = 1'b1;
        e_rd_en = 1'b0; e_wr_en = 1'b0; e_done = 1'b0; e_abort = 1'b0;
        obs_valid = 1'b0; sample = 1'b0;
        if (!rst_v) begin
            m_sync = 1'b1; m_frame = 1'b0; e_words = 0;
        end else if (m_sync) begin
            if (cs_v) m_sync = 1'b0;
        end else if (m_frame && cs_v) begin
            dw = (m_pos < HW) ? 0 : (m_pos - HW) / DW;
            if (dw > MB) dw = MB;
            e_done = 1'b1;
            e_words = dw;
            if (m_pos < HW) e_abort = 1'b1;
            else e_abort = (dw < MB) && (((m_pos - HW) % DW) != 0);
            m_frame = 1'b0;
        end else if (!cs_v) begin
            if (!m_frame) begin
                m_frame = 1'b1; m_pos = 0; m_hdr = '0;
            end
            p = m_pos;
            m_pos++;
            if (p < HW) begin
                m_hdr = {m_hdr[HW-2:0], mosi_v};
                if (p == RW - 1) begin
                    m_rdb = int'(m_hdr[RW-1:0]);
                    e_rd_en = 1'b1;
                    for (int i = 0; i < 2; i++) e_rd_addr[i] = RW'(m_rdb);
                end
                if (p == HW - 1) begin
                    m_wrb = int'(m_hdr[WW-1:0]);
                    sample = 1'b1;
                end
            end else if ((p - HW) / DW < MB) begin
                w = (p - HW) / DW;
                b = (p - HW) % DW;
                m_word = {m_word[DW-2:0], mosi_v};
                if (b == 0 && w + 1 < MB) begin
                    e_rd_en = 1'b1;
                    for (int i = 0; i < 2; i++) e_rd_addr[i] = RW'(m_rdb + (w + 1) * i);
                end
                if (b == DW - 1) begin
                    e_wr_en = 1'b1;
                    e_wr_data = m_word;
                    for (int i = 0; i < 2; i++) e_wr_addr[i] = WW'(m_wrb + w * i);
                    sample = 1'b1;
                end
            end
        end
        e_dis = m_sync || !m_frame;
        e_miso = '0;
        if (m_frame && m_pos >= HW && m_pos < HW + MB * DW) begin
            w = (m_pos - HW) / DW;
            b = (m_pos - HW) % DW;
            for (int i = 0; i < 2; i++) begin
                t = mem[(m_rdb + w * i) % 16];
                e_miso[i] = t[DW-1-b];
            end
            obs_valid = 1'b1;
            obs_w = w;
        end
        for (int i = 0; i < 2; i++) rd_data_v[i] = sample ? rd_lat[i] : DW'($urandom);
    endtask

    task automatic step(input bit rst_v, input bit cs_v, input bit mosi_v);
        @(negedge spi_clk_iob);
        #1;
        compare();
        reset_n  = rst_v;
        spi_cs_n = cs_v;
        spi_mosi = mosi_v;
        model(rst_v, cs_v, mosi_v);
    endtask

    // Sends header then data bits from tx[], `total` bits in all, keeping cs_n low.
    task automatic send_bits(input logic [HW-1:0] hdr, input int total);
        logic [DW-1:0] d;
        for (int j = 0; j < total; j++) begin
            if (j < HW) step(1'b1, 1'b0, hdr[HW-1-j]);
            else begin
                d = tx[((j - HW) / DW) % 8];
                step(1'b1, 1'b0, d[DW-1-((j - HW) % DW)]);
            end
        end
    endtask

    task automatic end_frame();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0; armed = 1'b0;
        reset_n = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        m_sync = 1'b1; m_frame = 1'b0; m_pos = 0; m_rdb = 0; m_wrb = 0;
        m_hdr = '0; m_word = '0; e_words = 0; e_miso = '0; e_wr_data = '0;
        for (int i = 0; i < 2; i++) begin
            rd_data_v[i] = '0; rd_lat[i] = '0; e_rd_addr[i] = '0; e_wr_addr[i] = '0;
        end
        for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
        for (int k = 0; k < 8; k++) tx[k] = DW'($urandom);
        clear_logs();

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_rd_addr", 1, 32'(rd_addr_v[1]), 32'h0);
        chk("rst_wr_addr", 1, 32'(wr_addr_v[1]), 32'h0);
        chk("rst_wr_data", 1, 32'(wr_data_v[1]), 32'h0);
        chk("rst_disable", 1, 32'(dis_v[1]), 32'h1);
        step(1'b1, 1'b1, 1'b0);

        // Single word
        mem[3] = 8'h5C; tx[0] = 8'hA7; clear_logs();
        send_bits(8'h35, HW + DW);
        end_frame();
        chk("t1_wr_cnt", 1, 32'(wr_cnt[1]), 32'd1);
        chk("t1_wr_addr", 1, 32'(wlog_a[1][0]), 32'h5);
        chk("t1_wr_data", 1, 32'(wlog_d[1][0]), 32'hA7);
        chk("t1_rd_addr", 1, 32'(rlog[1][0]), 32'h3);
        chk("t1_miso_word", 1, 32'(miso_obs[1][0]), 32'h5C);
        chk("t1_done", 1, 32'(done_cnt[1]), 32'd1);
        chk("t1_words", 1, 32'(last_words[1]), 32'd1);
        chk("t1_abort", 1, 32'(last_abort[1]), 32'd0);

        // Address wrap, rd_data = addr*0x10
        for (int a = 0; a < 16; a++) mem[a] = DW'(a * 16);
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; clear_logs();
        send_bits(8'hEF, HW + 3 * DW);
        end_frame();
        chk("t2_wr0", 1, 32'(wlog_a[1][0]), 32'hF);
        chk("t2_wr1", 1, 32'(wlog_a[1][1]), 32'h0);
        chk("t2_wr2", 1, 32'(wlog_a[1][2]), 32'h1);
        chk("t2_rd0", 1, 32'(rlog[1][0]), 32'hE);
        chk("t2_rd1", 1, 32'(rlog[1][1]), 32'hF);
        chk("t2_rd2", 1, 32'(rlog[1][2]), 32'h0);
        chk("t2_miso0", 1, 32'(miso_obs[1][0]), 32'hE0);
        chk("t2_miso1", 1, 32'(miso_obs[1][1]), 32'hF0);
        chk("t2_miso2", 1, 32'(miso_obs[1][2]), 32'h00);

        // Over-long burst
        for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
        for (int k = 0; k < 8; k++) tx[k] = DW'($urandom);
        clear_logs();
        send_bits(8'h00, HW + 6 * DW);
        end_frame();
        chk("t3_wr_cnt", 1, 32'(wr_cnt[1]), 32'd4);
        chk("t3_rd_cnt", 1, 32'(rd_cnt[1]), 32'd4);
        chk("t3_wr_last", 1, 32'(wlog_a[1][3]), 32'h3);
        chk("t3_words", 1, 32'(last_words[1]), 32'd4);
        chk("t3_abort", 1, 32'(last_abort[1]), 32'd0);

        // Abort mid-word
        clear_logs();
        send_bits(HW'($urandom), HW + DW + 5);
        end_frame();
        chk("t4_wr_cnt", 1, 32'(wr_cnt[1]), 32'd1);
        chk("t4_abort", 1, 32'(last_abort[1]), 32'd1);
        chk("t4_words", 1, 32'(last_words[1]), 32'd1);

        // Reset mid-frame, then cs_n held low with clocks running
        send_bits(HW'($urandom), HW + 2 * DW + 3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        clear_logs();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'($urandom));
        chk("t5_no_wr", 1, 32'(wr_cnt[1]), 32'd0);
        chk("t5_no_done", 1, 32'(done_cnt[1]), 32'd0);
        chk("t5_disable", 1, 32'(dis_v[1]), 32'h1);
        step(1'b1, 1'b1, 1'b0);
        send_bits(HW'($urandom), HW + 2 * DW);
        end_frame();
        chk("t5_done", 1, 32'(done_cnt[1]), 32'd1);
        chk("t5_words", 1, 32'(last_words[1]), 32'd2);

        // Fixed-address instance
        clear_logs();
        send_bits(8'h96, HW + 2 * DW);
        end_frame();
        chk("t6_wr_cnt", 0, 32'(wr_cnt[0]), 32'd2);
        chk("t6_wr0", 0, 32'(wlog_a[0][0]), 32'h6);
        chk("t6_wr1", 0, 32'(wlog_a[0][1]), 32'h6);
        chk("t6_rd_cnt", 0, 32'(rd_cnt[0]), 32'd3);
        chk("t6_rd1", 0, 32'(rlog[0][1]), 32'h9);
        chk("t6_rd2", 0, 32'(rlog[0][2]), 32'h9);

        // Randomized frames with occasional resets and header aborts
        for (int f = 0; f < 40; f++) begin
            for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
            for (int k = 0; k < 8; k++) tx[k] = DW'($urandom);
            send_bits(HW'($urandom), $urandom_range(1, HW + MB * DW + 10));
            if ($urandom_range(0, 9) == 0) begin
                step(1'b0, 1'($urandom), 1'b0);
                step(1'b1, 1'b0, 1'b1);
            end
            end_frame();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b1, 1'b1, 1'($urandom));
        end
        step(1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
